// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO              = 5'd0;
    localparam int         LOAD_STALL_CYCLES_DEF = 1;
    localparam int         STALL_CNT_W           = 3;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for the optional stall/flush statistics.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per cycle with inc high; hold at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall FSM and
// taken-branch flush generation. Outputs are combinational from state + inputs.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise StallCount/FlushCount are tied to zero.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
    parameter int CNT_W             = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteRegister,
    input  logic             MEM_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_noOp,
    output logic             EX_MEM_noOp,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Remaining stall cycles after the detection cycle.
    localparam logic [STALL_CNT_W-1:0] CNT_INIT = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [STALL_CNT_W-1:0] cnt;
    logic [STALL_CNT_W-1:0] cnt_nxt;
    logic                   hazard;

    // A load in EX writing a register the ID instruction reads; $zero never stalls.
    assign hazard = EX_MemRead && (EX_WriteRegister != REG_ZERO) &&
                    ((EX_WriteRegister == ID_Rs) ||
                     (ID_UsesRt && (EX_WriteRegister == ID_Rt)));

    // State register and stall down-counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and outputs; priority Rst > branch > ongoing stall > new hazard > run.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_noOp  = 1'b0;
        EX_MEM_noOp = 1'b0;
        Stalled     = 1'b0;

        if (Rst) begin
            // Hold the pipeline drained while in reset.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_noOp  = 1'b1;
            EX_MEM_noOp = 1'b1;
            state_nxt   = S_RUN;
            cnt_nxt     = '0;
        end else if (MEM_BranchTaken) begin
            // Redirect fetch and squash the three younger stages; any stalled
            // instruction is wrong-path, so the stall is abandoned.
            IF_ID_Flush = 1'b1;
            ID_EX_noOp  = 1'b1;
            EX_MEM_noOp = 1'b1;
            state_nxt   = S_RUN;
            cnt_nxt     = '0;
        end else if (state == S_STALL) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_noOp  = 1'b1;
            Stalled     = 1'b1;
            if (cnt == STALL_CNT_W'(1)) begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end else if (hazard) begin
            // The detection cycle is itself the first bubble.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_noOp  = 1'b1;
            Stalled     = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nxt = S_STALL;
                cnt_nxt   = CNT_INIT;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic flush_inc;

    assign flush_inc = MEM_BranchTaken && !Rst;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (Stalled),
        .count (StallCount)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (flush_inc),
        .count (FlushCount)
    );
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (1 and 3 bubbles per
// load-use) share stimulus; a bubble-budget reference model predicts outputs.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 32;

    logic       Clk;
    logic       Rst;
    logic [4:0] ID_Rs, ID_Rt, EX_WriteRegister;
    logic       ID_UsesRt, EX_MemRead, MEM_BranchTaken;

    logic          pc1, ifw1, iff1, idx1, exm1, st1;
    logic          pc3, ifw3, iff3, idx3, exm3, st3;
    logic [CW-1:0] sc1, fc1, sc3, fc3;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CW)) dut1 (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
        .MEM_BranchTaken(MEM_BranchTaken), .PCWrite(pc1), .IF_ID_Write(ifw1),
        .IF_ID_Flush(iff1), .ID_EX_noOp(idx1), .EX_MEM_noOp(exm1), .Stalled(st1),
        .StallCount(sc1), .FlushCount(fc1)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(CW)) dut3 (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
        .MEM_BranchTaken(MEM_BranchTaken), .PCWrite(pc3), .IF_ID_Write(ifw3),
        .IF_ID_Flush(iff3), .ID_EX_noOp(idx3), .EX_MEM_noOp(exm3), .Stalled(st3),
        .StallCount(sc3), .FlushCount(fc3)
    );

    // Clock starts high so the first compare edge (negedge) precedes the first posedge.
    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [5:0]  o1;
        logic [5:0]  o3;
        logic [31:0] s1, f1, s3, f3;
        bit          chk_cnt;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    // Reference model state: bubbles still owed per instance, event totals.
    int m_rem1 = 0, m_rem3 = 0;
    int m_sc1 = 0, m_fc1 = 0, m_sc3 = 0, m_fc3 = 0;
    bit m_rst_seen = 0;

    // Outputs packed as {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_noOp, EX_MEM_noOp, Stalled}.
    task automatic model_step(input int L, input bit rst, input bit br, input bit hz,
                              inout int rem, inout int sc, inout int fc,
                              output logic [5:0] o);
        if (rst) begin
            o   = 6'b001110;
            rem = 0; sc = 0; fc = 0;
        end else if (br) begin
            o   = 6'b111110;
            rem = 0;
            fc  = fc + 1;
        end else if (rem > 0) begin
            o   = 6'b000101;
            rem = rem - 1;
            sc  = sc + 1;
        end else if (hz) begin
            o   = 6'b000101;
            rem = L - 1;
            sc  = sc + 1;
        end else begin
            o   = 6'b110000;
        end
    endtask

    // Drive one cycle of inputs, push the prediction, then advance past the posedge.
    task automatic cyc(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urt, input bit mr, input logic [4:0] wr, input bit br);
        exp_t e;
        bit   hz;
        Rst = rst; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = urt;
        EX_MemRead = mr; EX_WriteRegister = wr; MEM_BranchTaken = br;
        hz = mr && (wr != 0) && ((wr == rs) || (urt && (wr == rt)));
`ifdef HAZARD_PERF_CNT_EN
        e.s1 = m_sc1; e.f1 = m_fc1; e.s3 = m_sc3; e.f3 = m_fc3;
`else
        e.s1 = 0; e.f1 = 0; e.s3 = 0; e.f3 = 0;
`endif
        e.chk_cnt = m_rst_seen;
        e.tag     = phase;
        model_step(1, rst, br, hz, m_rem1, m_sc1, m_fc1, e.o1);
        model_step(3, rst, br, hz, m_rem3, m_sc3, m_fc3, e.o3);
        if (rst) m_rst_seen = 1;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd1, 5'd2, 1, 0, 5'd0, 0);
    endtask

    // Monitor: combinational outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({pc1, ifw1, iff1, idx1, exm1, st1} !== e.o1) begin
                    errors++;
                    $display("FAIL %s outs_L1 t=%0t got %b exp %b", e.tag, $time,
                             {pc1, ifw1, iff1, idx1, exm1, st1}, e.o1);
                end
                checks++;
                if ({pc3, ifw3, iff3, idx3, exm3, st3} !== e.o3) begin
                    errors++;
                    $display("FAIL %s outs_L3 t=%0t got %b exp %b", e.tag, $time,
                             {pc3, ifw3, iff3, idx3, exm3, st3}, e.o3);
                end
                if (e.chk_cnt) begin
                    checks++;
                    if (sc1 !== e.s1 || fc1 !== e.f1 || sc3 !== e.s3 || fc3 !== e.f3) begin
                        errors++;
                        $display("FAIL %s perf t=%0t got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d",
                                 e.tag, $time, sc1, fc1, sc3, fc3, e.s1, e.f1, e.s3, e.f3);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        logic [4:0] regs [4];
        regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd17;

        phase = "reset";
        cyc(1, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        cyc(1, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        idle(2);

        phase = "loaduse_rs";
        cyc(0, 5'd8, 5'd3, 0, 1, 5'd8, 0);
        idle(4);

        phase = "loaduse_rt";
        cyc(0, 5'd4, 5'd9, 1, 1, 5'd9, 0);
        idle(4);
        phase = "rt_unused";
        cyc(0, 5'd4, 5'd9, 0, 1, 5'd9, 0);
        idle(1);

        phase = "zero_reg";
        cyc(0, 5'd0, 5'd0, 1, 1, 5'd0, 0);
        idle(1);

        phase = "hazard_held";
        cyc(0, 5'd8, 5'd8, 1, 1, 5'd8, 0);
        cyc(0, 5'd8, 5'd8, 1, 1, 5'd8, 0);
        cyc(0, 5'd8, 5'd8, 1, 1, 5'd8, 0);
        cyc(0, 5'd8, 5'd8, 1, 1, 5'd8, 0);
        idle(3);

        phase = "branch_mid_stall";
        cyc(0, 5'd9, 5'd1, 0, 1, 5'd9, 0);
        cyc(0, 5'd1, 5'd2, 0, 0, 5'd0, 1);
        idle(2);

        phase = "branch_and_hazard";
        cyc(0, 5'd8, 5'd1, 0, 1, 5'd8, 1);
        idle(2);

        phase = "perf";
        cyc(1, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        cyc(1, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        cyc(0, 5'd8, 5'd1, 0, 1, 5'd8, 0);
        idle(3);
        cyc(0, 5'd2, 5'd9, 1, 1, 5'd9, 0);
        idle(3);
        cyc(0, 5'd1, 5'd2, 0, 0, 5'd0, 1);
        idle(2);
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if (sc3 !== 32'd6 || fc3 !== 32'd1 || sc1 !== 32'd2 || fc1 !== 32'd1) begin
            errors++;
            $display("FAIL perf_totals got L3 %0d/%0d L1 %0d/%0d exp L3 6/1 L1 2/1",
                     sc3, fc3, sc1, fc1);
        end
`else
        if (sc3 !== 32'd0 || fc3 !== 32'd0 || sc1 !== 32'd0 || fc1 !== 32'd0) begin
            errors++;
            $display("FAIL perf_totals got L3 %0d/%0d L1 %0d/%0d exp all 0",
                     sc3, fc3, sc1, fc1);
        end
`endif

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                regs[$urandom_range(0, 3)], ($urandom_range(0, 99) < 10));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 5) begin
            @(negedge Clk);
            #1;
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
